// File: rtl/spi_master.sv
// SPI initiator for the 16-bit SPI_Slave command frame {WR, EXT_ADDR, FUTURE, REG_ADDR, DATA}.
// The SCLK period is 2*CLK_DIV system clocks. Read data is returned with a one-cycle rsp_valid pulse.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [2:0] cmd_ext_addr,
    input  logic [2:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso,
    input  logic       miso_oe
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic        tail;
    logic [15:0] shreg;
    logic [7:0]  rdata;
    logic        err;
    logic        wr_q;
    logic        tc;
    logic        accept;
    logic        fall;
    logic        done;

    assign tc     = (div_cnt == 8'(CLK_DIV - 1));
    assign accept = cmd_valid & cmd_ready;
    assign fall   = (state == SHIFT_HI) & tc;
    // HOLD spans two phases: a trailing low half-period after the last bit, then the cs hold time.
    assign done   = (state == HOLD) & tc & tail;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cs        = 1'b0;
        sclk      = 1'b0;
        mosi      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                cs   = 1'b1;
                mosi = shreg[15];
                if (tc) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                cs   = 1'b1;
                sclk = 1'b1;
                mosi = shreg[15];
                if (tc) state_nxt = (bit_cnt == 4'd15) ? HOLD : SHIFT_LO;
            end
            SHIFT_LO: begin
                cs   = 1'b1;
                mosi = shreg[15];
                if (tc) state_nxt = SHIFT_HI;
            end
            HOLD: begin
                cs = 1'b1;
                if (tc && tail) state_nxt = GAP;
            end
            GAP: begin
                if (tc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tail    <= 1'b0;
            shreg   <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) div_cnt <= '0;
            else               div_cnt <= tc ? 8'd0 : div_cnt + 8'd1;

            if (accept) begin
                shreg   <= {cmd_wr, cmd_ext_addr, 1'b0, cmd_reg_addr, cmd_wr ? cmd_wdata : 8'h00};
                wr_q    <= cmd_wr;
                bit_cnt <= '0;
                tail    <= 1'b0;
                rdata   <= '0;
                err     <= 1'b0;
            end else begin
                if (fall) begin
                    shreg <= {shreg[14:0], 1'b0};
                    if (bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
                    // Data phase of a read: shift in on the falling edge, slave drives on the previous fall.
                    if (!wr_q && bit_cnt[3]) begin
                        rdata <= {rdata[6:0], miso};
                        if (!miso_oe) err <= 1'b1;
                    end
                end
                if ((state == HOLD) && tc) tail <= ~tail;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (done) begin
                rsp_rdata <= wr_q ? 8'h00 : rdata;
                rsp_err   <= wr_q ? 1'b0 : err;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 instance and a CLK_DIV=1 instance driven by shared
// command buses, with a per-frame SPI slave model and a frame recorder.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
    logic       cmd_wr = 1'b0;
    logic [2:0] cmd_ext_addr = '0, cmd_reg_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       miso = 1'b0, miso_oe = 1'b1;

    logic       ready_a, rv_a, err_a, sclk_a, cs_a, mosi_a;
    logic       ready_b, rv_b, err_b, sclk_b, cs_b, mosi_b;
    logic [7:0] rd_a, rd_b;

    logic       sel = 1'b0;
    logic       m_ready, m_rv, m_err, m_sclk, m_cs, m_mosi;
    logic [7:0] m_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(ready_a),
        .cmd_wr(cmd_wr), .cmd_ext_addr(cmd_ext_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a),
        .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso), .miso_oe(miso_oe)
    );

    spi_master #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(ready_b),
        .cmd_wr(cmd_wr), .cmd_ext_addr(cmd_ext_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b),
        .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso), .miso_oe(miso_oe)
    );

    assign m_ready = sel ? ready_b : ready_a;
    assign m_rv    = sel ? rv_b    : rv_a;
    assign m_rd    = sel ? rd_b    : rd_a;
    assign m_err   = sel ? err_b   : err_a;
    assign m_sclk  = sel ? sclk_b  : sclk_a;
    assign m_cs    = sel ? cs_b    : cs_a;
    assign m_mosi  = sel ? mosi_b  : mosi_a;

    typedef struct {
        bit         sel;
        bit         wr;
        logic [2:0] ext;
        logic [2:0] rg;
        logic [7:0] wdata;
        logic [7:0] sdata;
        bit         soe;
        logic [15:0] exp_frame;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) cmd_valid_b = v;
        else     cmd_valid_a = v;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!m_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_ready) begin
            ok = 1'b0;
            check("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    // Issue one command and record the frame; the slave answers with v.sdata on sclk falls.
    task automatic frame(input vec_t v, input string tag);
        int c, k, rises, falls, hi_run, lo_run;
        logic [15:0] fr;
        logic [7:0] sd;
        bit phase_ok, cs_ok, rdy_ok, prev_sclk, done, ok;
        sel = v.sel;
        c = v.sel ? 1 : 4;
        sd = v.sdata;
        miso = v.soe ? 1'b0 : 1'b1;
        miso_oe = v.soe;
        @(posedge clk); #1;
        wait_ready(ok);
        if (!ok) return;
        cmd_wr = v.wr; cmd_ext_addr = v.ext; cmd_reg_addr = v.rg; cmd_wdata = v.wdata;
        set_valid(1'b1);
        @(posedge clk); #1;
        set_valid(1'b0);
        cmd_wr = ~v.wr; cmd_ext_addr = ~v.ext; cmd_reg_addr = ~v.rg; cmd_wdata = ~v.wdata;
        k = 0; rises = 0; falls = 0; hi_run = 0; lo_run = 0; fr = '0;
        phase_ok = 1; cs_ok = 1; rdy_ok = 1; prev_sclk = 0; done = 0;
        while (!done && k < 40 * c + 20) begin
            if (m_sclk && !prev_sclk) begin
                rises++;
                fr = {fr[14:0], m_mosi};
                if (rises > 1 && lo_run != c) phase_ok = 0;
                hi_run = 0;
            end
            if (!m_sclk && prev_sclk) begin
                falls++;
                if (hi_run != c) phase_ok = 0;
                lo_run = 0;
                if (v.soe && falls >= 8 && falls <= 15) miso = sd[15 - falls];
            end
            if (m_sclk) hi_run++;
            else        lo_run++;
            prev_sclk = m_sclk;
            if (m_rv) done = 1;
            else begin
                if (!m_cs) cs_ok = 0;
                if (m_ready) rdy_ok = 0;
                @(posedge clk); #1;
                k++;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, k, 34 * c);
        check({tag, "_rises"}, rises, 16);
        check({tag, "_frame"}, fr, v.exp_frame);
        check({tag, "_rdata"}, m_rd, v.exp_rdata);
        check({tag, "_err"}, 32'(m_err), 32'(v.exp_err));
        check({tag, "_cs_high"}, 32'(cs_ok), 32'd1);
        check({tag, "_ready_low"}, 32'(rdy_ok), 32'd1);
        check({tag, "_phases"}, 32'(phase_ok), 32'd1);
        check({tag, "_cs_drop"}, 32'(m_cs), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse_1cyc"}, 32'(m_rv), 32'd0);
        check({tag, "_rdata_held"}, m_rd, v.exp_rdata);
    endtask

    initial begin
        int k, rises, rsp_cnt, gap_low, rdy_k, viol;
        logic [31:0] fr2;
        bit ok, started2, rv_seen;

        vecs[0] = '{0, 1, 3'b111, 3'b111, 8'hAA, 8'h00, 1, 16'hF7AA, 8'h00, 0};
        vecs[1] = '{0, 0, 3'b111, 3'b111, 8'hFF, 8'h5C, 1, 16'h7700, 8'h5C, 0};
        vecs[2] = '{0, 0, 3'b111, 3'b111, 8'h00, 8'hFF, 0, 16'h7700, 8'hFF, 1};
        vecs[3] = '{0, 1, 3'b001, 3'b001, 8'h0F, 8'h00, 1, 16'h910F, 8'h00, 0};
        vecs[4] = '{1, 1, 3'b010, 3'b011, 8'hA5, 8'h00, 1, 16'hA3A5, 8'h00, 0};
        vecs[5] = '{0, 0, 3'b000, 3'b000, 8'h00, 8'h81, 1, 16'h0000, 8'h81, 0};
        vecs[6] = '{0, 1, 3'b101, 3'b110, 8'h3C, 8'h00, 0, 16'hD63C, 8'h00, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_a", 32'(ready_a), 1);
        check("rst_outs_a", {sclk_a, cs_a, mosi_a, rv_a, err_a}, 0);
        check("rst_rdata_a", rd_a, 0);
        check("rst_ready_b", 32'(ready_b), 1);
        check("rst_outs_b", {sclk_b, cs_b, mosi_b, rv_b, err_b, rd_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (i != 3) frame(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back writes with cmd_valid held high on the CLK_DIV=4 instance.
        sel = 0;
        @(posedge clk); #1;
        wait_ready(ok);
        cmd_wr = 1; cmd_ext_addr = 3'd7; cmd_reg_addr = 3'd2; cmd_wdata = 8'h12;
        cmd_valid_a = 1;
        @(posedge clk); #1;
        cmd_reg_addr = 3'd5; cmd_wdata = 8'h34;
        k = 0; rises = 0; rsp_cnt = 0; gap_low = 0; rdy_k = -1; viol = 0; fr2 = '0;
        started2 = 0; rv_seen = 0;
        begin
            logic prev = 0;
            while (rsp_cnt < 2 && k < 80 * 4) begin
                if (sclk_a && !prev) begin rises++; fr2 = {fr2[30:0], mosi_a}; end
                prev = sclk_a;
                if (rv_a) rsp_cnt++;
                if (rsp_cnt == 1 && cs_a) started2 = 1;
                if (rsp_cnt == 1 && !started2 && !cs_a) gap_low++;
                if (cs_a && ready_a) viol++;
                if (rsp_cnt == 1 && ready_a && rdy_k < 0) rdy_k = k;
                if (rdy_k >= 0 && k == rdy_k + 1) cmd_valid_a = 0;
                if (rsp_cnt < 2) begin @(posedge clk); #1; k++; end
            end
        end
        cmd_valid_a = 0;
        check("b2b_frames", fr2, 32'hF212F534);
        check("b2b_rises", rises, 32);
        check("b2b_rsp_cnt", rsp_cnt, 2);
        check("b2b_gap_low", gap_low, 4 + 1);
        check("b2b_reaccept", rdy_k + 1, 35 * 4 + 1);
        check("b2b_ready_in_frame", viol, 0);
        check("b2b_total", k, 34 * 4 + 35 * 4 + 1);

        // Reset in the middle of a frame: outputs clear without a clock edge, no response.
        @(posedge clk); #1;
        wait_ready(ok);
        cmd_wr = 1; cmd_ext_addr = 3'd7; cmd_reg_addr = 3'd7; cmd_wdata = 8'h55;
        cmd_valid_a = 1;
        @(posedge clk); #1;
        cmd_valid_a = 0;
        begin
            logic prev = 0;
            rises = 0; k = 0;
            while (rises < 5 && k < 200) begin
                if (sclk_a && !prev) rises++;
                prev = sclk_a;
                if (rises < 5) begin @(posedge clk); #1; k++; end
            end
        end
        check("mid_reached_5th_rise", rises, 5);
        check("mid_pre_rst_active", {sclk_a, cs_a}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("mid_async_clear", {sclk_a, cs_a, mosi_a}, 0);
        rv_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rv_a) rv_seen = 1;
        end
        check("mid_no_rsp", 32'(rv_seen), 0);
        check("mid_ready", 32'(ready_a), 1);
        @(negedge clk);
        rst_n = 1'b1;
        frame(vecs[3], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
